// File: rtl/bster_mem_driver.sv
// Single-beat AXI4 memory driver for the tree engines.
// One outstanding read or write; sticky error on non-OKAY responses.
module bster_mem_driver #(
  parameter int RAM_DATA_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int RAM_STRB_WIDTH = RAM_DATA_WIDTH / 8
) (
  input  logic                      aclk_i,
  input  logic                      areset_i,
  input  logic                      mem_valid_i,
  output logic                      mem_ready_o,
  input  logic                      mem_rd_i,
  input  logic                      mem_wr_i,
  input  logic [RAM_ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [RAM_DATA_WIDTH-1:0] mem_wr_data_i,
  output logic                      mem_rd_valid_o,
  input  logic                      mem_rd_ready_i,
  output logic [RAM_DATA_WIDTH-1:0] mem_rd_data_o,
  output logic                      awvalid_o,
  input  logic                      awready_i,
  output logic [RAM_ADDR_WIDTH-1:0] awaddr_o,
  output logic                      wvalid_o,
  input  logic                      wready_i,
  output logic [RAM_DATA_WIDTH-1:0] wdata_o,
  input  logic                      bvalid_i,
  output logic                      bready_o,
  input  logic [1:0]                bresp_i,
  output logic                      arvalid_o,
  input  logic                      arready_i,
  output logic [RAM_ADDR_WIDTH-1:0] araddr_o,
  input  logic                      rvalid_i,
  output logic                      rready_o,
  input  logic [RAM_DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]                rresp_i,
  output logic                      mem_error_o
);

  localparam int SH = $clog2(RAM_STRB_WIDTH);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, RD_CPL, WR_REQ, WR_RESP
  } state_e;

  state_e state_q, state_d;

  logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RAM_DATA_WIDTH-1:0] wr_data_q;
  logic [RAM_DATA_WIDTH-1:0] rd_data_q;
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;
  logic err_q;

  logic accept, aw_fire, w_fire, wr_both;
  logic err_set;

  assign accept  = mem_valid_i && mem_ready_o;
  assign addr_d  = mem_addr_i << SH;
  assign aw_fire = awvalid_o && awready_i;
  assign w_fire  = wvalid_o && wready_i;
  assign wr_both = (aw_done_q || aw_fire) && (w_done_q || w_fire);

  assign err_set =
    (state_q == RD_DATA && rvalid_i && rresp_i != 2'b00) ||
    (state_q == WR_RESP && bvalid_i && bresp_i != 2'b00);

  // Done flags only live inside WR_REQ; cleared on the way out.
  always_comb begin
    aw_done_d = 1'b0;
    w_done_d  = 1'b0;
    if (state_q == WR_REQ && !wr_both) begin
      aw_done_d = aw_done_q || aw_fire;
      w_done_d  = w_done_q || w_fire;
    end
  end

  always_ff @(posedge aclk_i) begin
    if (areset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (mem_rd_i)      state_d = RD_ADDR;
          else if (mem_wr_i) state_d = WR_REQ;
        end
      end
      RD_ADDR: if (arready_i)      state_d = RD_DATA;
      RD_DATA: if (rvalid_i)       state_d = RD_CPL;
      RD_CPL:  if (mem_rd_ready_i) state_d = IDLE;
      WR_REQ:  if (wr_both)        state_d = WR_RESP;
      WR_RESP: if (bvalid_i)       state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_ready_o    = (state_q == IDLE) && !areset_i;
    arvalid_o      = (state_q == RD_ADDR);
    rready_o       = (state_q == RD_DATA);
    mem_rd_valid_o = (state_q == RD_CPL);
    awvalid_o      = (state_q == WR_REQ) && !aw_done_q;
    wvalid_o       = (state_q == WR_REQ) && !w_done_q;
    bready_o       = (state_q == WR_RESP);
  end

  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      addr_q    <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= addr_d;
        wr_data_q <= mem_wr_data_i;
      end
      if (state_q == RD_DATA && rvalid_i)
        rd_data_q <= rdata_i;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (err_set) err_q <= 1'b1;
    end
  end

  assign araddr_o      = addr_q;
  assign awaddr_o      = addr_q;
  assign wdata_o       = wr_data_q;
  assign mem_rd_data_o = rd_data_q;
  assign mem_error_o   = err_q;

endmodule
